// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the encoder -> channel -> Viterbi decoder test link.
// Optional channel error injection is built only when VITERBI_ERR_INJ_EN is defined.
module viterbi_frame_ctrl #(
  parameter int FRAME_LEN  = 256,
  parameter int TAIL_LEN   = 2,
  parameter int DRAIN_LEN  = 64,
  parameter int ERR_PERIOD = 32,
  parameter int ERR_BURST  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        inj_on_i,
  input  logic        src_valid_i,
  input  logic        src_bit_i,
  output logic        src_ready_o,
  output logic        enc_enable_o,
  output logic        enc_bit_o,
  input  logic        enc_valid_i,
  output logic [1:0]  err_mask_o,
  output logic        dec_enable_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] frame_ct_o,
  output logic [15:0] inj_ct_o
);

  // state   | meaning
  // IDLE    | waiting for start_i, encoder idle
  // PAYLOAD | forwarding source bits to the encoder
  // TAIL    | feeding zero flush bits
  // DRAIN   | waiting for decoder traceback
  // DONE    | one-cycle completion pulse
  typedef enum logic [2:0] {IDLE, PAYLOAD, TAIL, DRAIN, DONE} state_t;

  localparam int BIT_W   = $clog2(FRAME_LEN + 1);
  localparam int TAIL_W  = $clog2(TAIL_LEN + 1);
  localparam int DRAIN_W = $clog2(DRAIN_LEN + 1);

  state_t             state, state_nx;
  logic [BIT_W-1:0]   bit_ct;
  logic [TAIL_W-1:0]  tail_ct;
  logic [DRAIN_W-1:0] drain_ct;
  logic               handshake;
  logic               start_acc;

  assign start_acc = (state == IDLE) && start_i;
  assign handshake = src_valid_i && src_ready_o;
  assign busy_o    = (state != IDLE);
  assign done_o    = (state == DONE);

  always_comb begin
    state_nx     = state;
    src_ready_o  = 1'b0;
    enc_enable_o = 1'b0;
    enc_bit_o    = 1'b0;
    case (state)
      IDLE: if (start_i) state_nx = PAYLOAD;
      PAYLOAD: begin
        src_ready_o = 1'b1;
        if (src_valid_i) begin
          enc_enable_o = 1'b1;
          enc_bit_o    = src_bit_i;
          if (bit_ct == BIT_W'(FRAME_LEN - 1)) state_nx = TAIL;
        end
      end
      TAIL: begin
        enc_enable_o = 1'b1;
        if (tail_ct == TAIL_W'(TAIL_LEN - 1)) state_nx = DRAIN;
      end
      DRAIN: if (drain_ct == DRAIN_W'(DRAIN_LEN - 1)) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bit_ct       <= '0;
      tail_ct      <= '0;
      drain_ct     <= '0;
      frame_ct_o   <= '0;
      dec_enable_o <= 1'b0;
    end else begin
      state        <= state_nx;
      dec_enable_o <= enc_valid_i;
      if (start_acc) begin
        bit_ct   <= '0;
        tail_ct  <= '0;
        drain_ct <= '0;
      end
      if (state == PAYLOAD && handshake) bit_ct <= bit_ct + 1'b1;
      if (state == TAIL) tail_ct <= tail_ct + 1'b1;
      if (state == DRAIN) drain_ct <= drain_ct + 1'b1;
      if (state == DONE) frame_ct_o <= frame_ct_o + 16'd1;
    end
  end

`ifdef VITERBI_ERR_INJ_EN
  localparam int SYM_W = $clog2(ERR_PERIOD);

  logic [SYM_W-1:0] sym_ct;
  logic             inj_active;
  logic             inject;

  // The corrupted burst sits at the tail end of each symbol window.
  assign inject     = inj_active && enc_valid_i &&
                      (sym_ct >= SYM_W'(ERR_PERIOD - ERR_BURST));
  assign err_mask_o = {inject, inject};

  always_ff @(posedge clk) begin
    if (rst) begin
      sym_ct     <= '0;
      inj_active <= 1'b0;
      inj_ct_o   <= '0;
    end else begin
      if (start_acc) begin
        sym_ct     <= '0;
        inj_active <= inj_on_i;
      end else begin
        if (enc_valid_i)
          sym_ct <= (sym_ct == SYM_W'(ERR_PERIOD - 1)) ? '0 : sym_ct + 1'b1;
        if (state == DONE) inj_active <= 1'b0;
      end
      if (inject && inj_ct_o != 16'hFFFF) inj_ct_o <= inj_ct_o + 16'd1;
    end
  end
`else
  logic unused_inj_on;

  assign unused_inj_on = inj_on_i;
  assign err_mask_o    = 2'b00;
  assign inj_ct_o      = 16'd0;
`endif

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Directed self-checking bench for viterbi_frame_ctrl (FRAME_LEN=8, TAIL_LEN=2,
// DRAIN_LEN=4, ERR_PERIOD=4, ERR_BURST=1); cycle 0 is the start_i cycle.
module tb_viterbi_frame_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, inj_on_i, src_valid_i, src_bit_i;
  logic        src_ready_o, enc_enable_o, enc_bit_o;
  logic        enc_valid_i = 1'b0;
  logic [1:0]  err_mask_o;
  logic        dec_enable_o, busy_o, done_o;
  logic [15:0] frame_ct_o, inj_ct_o;

  int chk_ct  = 0;
  int pass_ct = 0;

  viterbi_frame_ctrl #(
    .FRAME_LEN(8), .TAIL_LEN(2), .DRAIN_LEN(4), .ERR_PERIOD(4), .ERR_BURST(1)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .inj_on_i(inj_on_i),
    .src_valid_i(src_valid_i), .src_bit_i(src_bit_i), .src_ready_o(src_ready_o),
    .enc_enable_o(enc_enable_o), .enc_bit_o(enc_bit_o), .enc_valid_i(enc_valid_i),
    .err_mask_o(err_mask_o), .dec_enable_o(dec_enable_o), .busy_o(busy_o),
    .done_o(done_o), .frame_ct_o(frame_ct_o), .inj_ct_o(inj_ct_o)
  );

  always #5 clk = ~clk;

  // Encoder model: valid follows enable by one cycle.
  always @(posedge clk) enc_valid_i <= enc_enable_o;

  task automatic do_reset();
    rst = 1'b1; start_i = 1'b0; inj_on_i = 1'b0; src_valid_i = 1'b0; src_bit_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Runs ncyc cycles from the start cycle and records per-cycle outputs.
  task automatic run_frame(input logic [7:0] payload, input logic inj, input logic [39:0] bubble,
                           input int start2, input int ncyc,
                           output logic [39:0] en_v, output logic [39:0] bit_v,
                           output logic [39:0] rdy_v, output logic [39:0] busy_v,
                           output logic [39:0] done_v, output logic [39:0] dec_v,
                           output logic [39:0] mhi_v, output logic [39:0] mlo_v);
    logic [7:0] shreg;
    shreg = payload;
    en_v = '0; bit_v = '0; rdy_v = '0; busy_v = '0; done_v = '0; dec_v = '0; mhi_v = '0; mlo_v = '0;
    inj_on_i = inj;
    for (int c = 0; c < ncyc; c++) begin
      start_i     = (c == 0) || (c == start2);
      src_valid_i = !bubble[c];
      src_bit_i   = shreg[7];
      @(negedge clk);
      en_v[c] = enc_enable_o; bit_v[c] = enc_bit_o; rdy_v[c] = src_ready_o;
      busy_v[c] = busy_o; done_v[c] = done_o; dec_v[c] = dec_enable_o;
      mhi_v[c] = err_mask_o[1]; mlo_v[c] = err_mask_o[0];
      if (src_valid_i && src_ready_o) shreg = shreg << 1;
      @(posedge clk);
      #1;
    end
    start_i = 1'b0; src_valid_i = 1'b0; src_bit_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    chk_ct++;
    if ({src_ready_o, enc_enable_o, enc_bit_o, err_mask_o, dec_enable_o, busy_o, done_o} !== 8'h00)
      $display("FAIL reset_outputs: got %b, want 00000000",
               {src_ready_o, enc_enable_o, enc_bit_o, err_mask_o, dec_enable_o, busy_o, done_o});
    else pass_ct++;
    chk_ct++;
    if ({frame_ct_o, inj_ct_o} !== 32'h0)
      $display("FAIL reset_counters: got frame=%0d inj=%0d, want 0/0", frame_ct_o, inj_ct_o);
    else pass_ct++;
  endtask

  task automatic test_clean();
    logic [39:0] en_v, bit_v, rdy_v, busy_v, done_v, dec_v, mhi_v, mlo_v;
    do_reset();
    run_frame(8'b10110010, 1'b0, 40'h0, -1, 18, en_v, bit_v, rdy_v, busy_v, done_v, dec_v, mhi_v, mlo_v);
    chk_ct++; if (en_v !== 40'h7FE) $display("FAIL clean_enable: got %h, want 7fe", en_v); else pass_ct++;
    chk_ct++; if (bit_v !== 40'h9A) $display("FAIL clean_bits: got %h, want 9a", bit_v); else pass_ct++;
    chk_ct++; if (rdy_v !== 40'h1FE) $display("FAIL clean_ready: got %h, want 1fe", rdy_v); else pass_ct++;
    chk_ct++; if (done_v !== 40'h8000) $display("FAIL clean_done: got %h, want 8000", done_v); else pass_ct++;
    chk_ct++; if (busy_v !== 40'hFFFE) $display("FAIL clean_busy: got %h, want fffe", busy_v); else pass_ct++;
    chk_ct++; if (dec_v !== 40'h1FF8) $display("FAIL clean_dec_enable: got %h, want 1ff8", dec_v); else pass_ct++;
    chk_ct++; if ((mhi_v | mlo_v) !== 40'h0) $display("FAIL clean_mask: got %h, want 0", mhi_v | mlo_v); else pass_ct++;
    chk_ct++; if (frame_ct_o !== 16'd1) $display("FAIL clean_frame_ct: got %0d, want 1", frame_ct_o); else pass_ct++;
  endtask

  task automatic test_injection();
    logic [39:0] en_v, bit_v, rdy_v, busy_v, done_v, dec_v, mhi_v, mlo_v;
    do_reset();
    run_frame(8'b10110010, 1'b1, 40'h0, -1, 18, en_v, bit_v, rdy_v, busy_v, done_v, dec_v, mhi_v, mlo_v);
`ifdef VITERBI_ERR_INJ_EN
    // Symbols arrive on cycles 2..11; the 4th and 8th are cycles 5 and 9.
    chk_ct++; if (mhi_v !== 40'h220) $display("FAIL inj_mask_hi: got %h, want 220", mhi_v); else pass_ct++;
    chk_ct++; if (mlo_v !== 40'h220) $display("FAIL inj_mask_lo: got %h, want 220", mlo_v); else pass_ct++;
    chk_ct++; if (inj_ct_o !== 16'd2) $display("FAIL inj_count: got %0d, want 2", inj_ct_o); else pass_ct++;
`else
    chk_ct++; if ((mhi_v | mlo_v) !== 40'h0) $display("FAIL noinj_mask: got %h, want 0", mhi_v | mlo_v); else pass_ct++;
    chk_ct++; if (inj_ct_o !== 16'd0) $display("FAIL noinj_count: got %0d, want 0", inj_ct_o); else pass_ct++;
`endif
    chk_ct++; if (en_v !== 40'h7FE) $display("FAIL inj_enable: got %h, want 7fe", en_v); else pass_ct++;
    chk_ct++; if (done_v !== 40'h8000) $display("FAIL inj_done: got %h, want 8000", done_v); else pass_ct++;
  endtask

  task automatic test_bubbles();
    logic [39:0] en_v, bit_v, rdy_v, busy_v, done_v, dec_v, mhi_v, mlo_v;
    do_reset();
    run_frame(8'b10110010, 1'b0, 40'h18, -1, 20, en_v, bit_v, rdy_v, busy_v, done_v, dec_v, mhi_v, mlo_v);
    chk_ct++; if (en_v !== 40'h1FE6) $display("FAIL bubble_enable: got %h, want 1fe6", en_v); else pass_ct++;
    chk_ct++; if (bit_v !== 40'h262) $display("FAIL bubble_bits: got %h, want 262", bit_v); else pass_ct++;
    chk_ct++; if (rdy_v !== 40'h7FE) $display("FAIL bubble_ready: got %h, want 7fe", rdy_v); else pass_ct++;
    chk_ct++; if (done_v !== 40'h20000) $display("FAIL bubble_done: got %h, want 20000", done_v); else pass_ct++;
  endtask

  task automatic test_start_ignored();
    logic [39:0] en_v, bit_v, rdy_v, busy_v, done_v, dec_v, mhi_v, mlo_v;
    do_reset();
    run_frame(8'b10110010, 1'b0, 40'h0, 5, 20, en_v, bit_v, rdy_v, busy_v, done_v, dec_v, mhi_v, mlo_v);
    chk_ct++; if (done_v !== 40'h8000) $display("FAIL midstart_done: got %h, want 8000", done_v); else pass_ct++;
    chk_ct++; if (busy_v !== 40'hFFFE) $display("FAIL midstart_busy: got %h, want fffe", busy_v); else pass_ct++;
    chk_ct++; if (frame_ct_o !== 16'd1) $display("FAIL midstart_frame_ct: got %0d, want 1", frame_ct_o); else pass_ct++;
  endtask

  task automatic test_back_to_back();
    logic [39:0] en_v, bit_v, rdy_v, busy_v, done_v, dec_v, mhi_v, mlo_v;
    do_reset();
    run_frame(8'b11111111, 1'b0, 40'h0, 16, 34, en_v, bit_v, rdy_v, busy_v, done_v, dec_v, mhi_v, mlo_v);
    chk_ct++; if (done_v !== 40'h8000_8000) $display("FAIL b2b_done: got %h, want 80008000", done_v); else pass_ct++;
    chk_ct++; if (en_v !== 40'h07FE_07FE) $display("FAIL b2b_enable: got %h, want 07fe07fe", en_v); else pass_ct++;
    chk_ct++; if (frame_ct_o !== 16'd2) $display("FAIL b2b_frame_ct: got %0d, want 2", frame_ct_o); else pass_ct++;
  endtask

  task automatic test_mid_reset();
    logic [39:0] en_v, bit_v, rdy_v, busy_v, done_v, dec_v, mhi_v, mlo_v;
    do_reset();
    inj_on_i = 1'b1;
    for (int c = 0; c < 7; c++) begin
      start_i = (c == 0); src_valid_i = 1'b1; src_bit_i = 1'b0; rst = (c == 6);
      @(negedge clk);
      if (c == 6) begin
        chk_ct++; if (busy_o !== 1'b1) $display("FAIL midrst_pre_busy: got %b, want 1", busy_o); else pass_ct++;
`ifdef VITERBI_ERR_INJ_EN
        chk_ct++; if (inj_ct_o !== 16'd1) $display("FAIL midrst_pre_inj: got %0d, want 1", inj_ct_o); else pass_ct++;
`endif
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0; start_i = 1'b0; src_valid_i = 1'b0;
    @(negedge clk);
    chk_ct++;
    if ({busy_o, done_o, src_ready_o, enc_enable_o, dec_enable_o, err_mask_o} !== 7'b0)
      $display("FAIL midrst_outputs: got %b, want 0000000",
               {busy_o, done_o, src_ready_o, enc_enable_o, dec_enable_o, err_mask_o});
    else pass_ct++;
    chk_ct++;
    if ({frame_ct_o, inj_ct_o} !== 32'h0)
      $display("FAIL midrst_counters: got frame=%0d inj=%0d, want 0/0", frame_ct_o, inj_ct_o);
    else pass_ct++;
    @(posedge clk);
    #1;
    run_frame(8'b10110010, 1'b0, 40'h0, -1, 18, en_v, bit_v, rdy_v, busy_v, done_v, dec_v, mhi_v, mlo_v);
    chk_ct++; if (done_v !== 40'h8000) $display("FAIL midrst_rerun_done: got %h, want 8000", done_v); else pass_ct++;
    chk_ct++; if (bit_v !== 40'h9A) $display("FAIL midrst_rerun_bits: got %h, want 9a", bit_v); else pass_ct++;
    chk_ct++; if (frame_ct_o !== 16'd1) $display("FAIL midrst_rerun_frame_ct: got %0d, want 1", frame_ct_o); else pass_ct++;
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; inj_on_i = 1'b0; src_valid_i = 1'b0; src_bit_i = 1'b0;
    test_reset();
    test_clean();
    test_injection();
    test_bubbles();
    test_start_ignored();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_ct, chk_ct);
    $finish;
  end

endmodule
